// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared types and helpers for the key scan path.
//   NKEYS          number of keys behind the 4-to-16 decoder
//   KW             key index width
//   key_evt_t      one queued key event {code, press}
//   sel_dec_t      decoded select {valid, idx}
//   onehot_low_idx decode an active-low one-hot select bus
package key_scan_pkg;

  localparam int NKEYS = 16;
  localparam int KW    = 4;

  typedef struct packed {
    logic [KW-1:0] code;
    logic          press;
  } key_evt_t;

  typedef struct packed {
    logic          valid;
    logic [KW-1:0] idx;
  } sel_dec_t;

  // valid only when exactly one select line is low; idx is that line
  function automatic sel_dec_t onehot_low_idx(input logic [NKEYS-1:0] sel);
    sel_dec_t   res;
    logic [4:0] zeros;
    res.valid = 1'b0;
    res.idx   = {KW{1'b0}};
    zeros     = 5'd0;
    for (int i = 0; i < NKEYS; i++) begin
      if (!sel[i]) begin
        zeros   = zeros + 5'd1;
        res.idx = i[KW-1:0];
      end
    end
    res.valid = (zeros == 5'd1);
    return res;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: synchronous show-ahead FIFO of key events.
// Ports:
//   clk    clock, rising edge
//   clr    synchronous active-high clear
//   push   write din (accepted when not full, or when full and popping)
//   din    event to write
//   pop    remove head (ignored when empty)
//   head   current head event, all zero when empty
//   full   DEPTH entries held
//   empty  no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module key_evt_fifo
  import key_scan_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     clr,
  input  logic     push,
  input  key_evt_t din,
  input  logic     pop,
  output key_evt_t head,
  output logic     full,
  output logic     empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  key_evt_t      mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // accept/commit decisions; a full FIFO still takes a push when it pops
  always_comb begin
    full      = (count_r == DEPTH_C);
    empty     = (count_r == {(AW+1){1'b0}});
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    if (empty) begin
      head = '0;
    end else begin
      head = mem_r[rd_ptr_r];
    end
  end

  // storage array; contents are only observed through head when non-empty
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/key_event_collector.sv
// key_event_collector: debounces the 16 scanned keys and queues press/release
// events for a valid/ready consumer.
// Ports:
//   CLK        clock, rising edge
//   CLRBAR     synchronous active-high clear (name kept from the codebase)
//   SEL        active-low one-hot key select; all-high = blank
//   SENSE      matrix return, 1 = selected key closed
//   EVT_VALID  FIFO head holds an event
//   EVT_READY  consumer takes the head when EVT_VALID & EVT_READY
//   EVT_CODE   key index of the head event
//   EVT_PRESS  1 = press, 0 = release
//   KEYS       debounced key map
//   OVERFLOW   sticky: an event was dropped on a full FIFO
// Build option: KEY_RELEASE_EVT_EN queues release events too; without it only
// presses are queued, though releases still update KEYS.
module key_event_collector
  import key_scan_pkg::*;
#(
  parameter int DEB        = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             CLRBAR,
  input  logic [NKEYS-1:0] SEL,
  input  logic             SENSE,
  output logic             EVT_VALID,
  input  logic             EVT_READY,
  output logic [KW-1:0]    EVT_CODE,
  output logic             EVT_PRESS,
  output logic [NKEYS-1:0] KEYS,
  output logic             OVERFLOW
);

  localparam logic [3:0] DEB_LAST = 4'(DEB - 1);

  logic [NKEYS-1:0] keys_r;
  logic [3:0]       cnt_r [NKEYS];
  logic             ovf_r;

  sel_dec_t   dec_s;
  logic       cur_key_s;
  logic [3:0] cur_cnt_s;
  logic       flip_s;
  logic       push_s;
  logic       pop_s;
  key_evt_t   evt_in_s;
  key_evt_t   head_s;
  logic       full_s;
  logic       empty_s;

  // debounce decision for the currently selected key
  always_comb begin
    dec_s     = onehot_low_idx(SEL);
    cur_key_s = keys_r[dec_s.idx];
    cur_cnt_s = cnt_r[dec_s.idx];
    if (dec_s.valid && (SENSE != cur_key_s) && (cur_cnt_s == DEB_LAST)) begin
      flip_s = 1'b1;
    end else begin
      flip_s = 1'b0;
    end
    evt_in_s.code = dec_s.idx;
`ifdef KEY_RELEASE_EVT_EN
    evt_in_s.press = SENSE;
    push_s         = flip_s;
`else
    evt_in_s.press = 1'b1;
    push_s         = flip_s & SENSE;
`endif
    pop_s = ~empty_s & EVT_READY;
  end

  // per-key counters and debounced map; only the selected key moves
  always_ff @(posedge CLK) begin
    if (CLRBAR) begin
      keys_r <= {NKEYS{1'b0}};
      for (int i = 0; i < NKEYS; i++) begin
        cnt_r[i] <= 4'd0;
      end
    end else if (dec_s.valid) begin
      if (SENSE == cur_key_s) begin
        cnt_r[dec_s.idx] <= 4'd0;
      end else if (flip_s) begin
        keys_r[dec_s.idx] <= SENSE;
        cnt_r[dec_s.idx]  <= 4'd0;
      end else begin
        cnt_r[dec_s.idx] <= cur_cnt_s + 4'd1;
      end
    end
  end

  // sticky overflow: push lost because the FIFO was full and not popping
  always_ff @(posedge CLK) begin
    if (CLRBAR) begin
      ovf_r <= 1'b0;
    end else if (push_s && full_s && !pop_s) begin
      ovf_r <= 1'b1;
    end
  end

  key_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .clr  (CLRBAR),
    .push (push_s),
    .din  (evt_in_s),
    .pop  (pop_s),
    .head (head_s),
    .full (full_s),
    .empty(empty_s)
  );

  assign EVT_VALID = ~empty_s;
  assign EVT_CODE  = head_s.code;
  assign EVT_PRESS = head_s.press;
  assign KEYS      = keys_r;
  assign OVERFLOW  = ovf_r;

endmodule

// File: tb/tb_key_event_collector.sv
// Self-checking bench for key_event_collector (DEB=4, FIFO_DEPTH=4).
// A behavioural model queues expected events as stimulus is applied; the
// head of that queue is compared whenever the DUT presents an event.
module tb_key_event_collector;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;
`ifdef KEY_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        CLRBAR = 1'b1;
  logic [15:0] SEL = 16'hFFFF;
  logic        SENSE = 1'b0;
  logic        EVT_VALID;
  logic        EVT_READY = 1'b0;
  logic [3:0]  EVT_CODE;
  logic        EVT_PRESS;
  logic [15:0] KEYS;
  logic        OVERFLOW;

  key_event_collector #(.DEB(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .CLRBAR(CLRBAR), .SEL(SEL), .SENSE(SENSE),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_CODE(EVT_CODE),
    .EVT_PRESS(EVT_PRESS), .KEYS(KEYS), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_keys;
  int          m_cnt [16];
  logic        m_ovf;
  logic [4:0]  m_q [$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_keys = 16'h0000;
    m_ovf  = 1'b0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_q.delete();
  endtask

  // compare DUT state/head against the model (called between edges)
  task automatic check_outputs();
    chk("keys", KEYS, m_keys);
    chk("overflow", {15'd0, OVERFLOW}, {15'd0, m_ovf});
    chk("evt_valid", {15'd0, EVT_VALID}, {15'd0, (m_q.size() > 0)});
    if (m_q.size() > 0) begin
      chk("evt_code", {12'd0, EVT_CODE}, {12'd0, m_q[0][4:1]});
      chk("evt_press", {15'd0, EVT_PRESS}, {15'd0, m_q[0][0]});
    end else begin
      chk("empty_code", {12'd0, EVT_CODE}, 16'h0000);
      chk("empty_press", {15'd0, EVT_PRESS}, 16'h0000);
    end
  endtask

  // advance the model by one clock edge with the given inputs
  task automatic model_step(input logic [15:0] sel, input logic sense, input logic rdy);
    int idx;
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if ($countones(~sel) == 1) begin
      idx = 0;
      for (int i = 0; i < 16; i++) if (sel[i] == 1'b0) idx = i;
      if (sense == m_keys[idx]) begin
        m_cnt[idx] = 0;
      end else if (m_cnt[idx] < DEB - 1) begin
        m_cnt[idx] = m_cnt[idx] + 1;
      end else begin
        m_keys[idx] = sense;
        m_cnt[idx]  = 0;
        if (sense || REL) begin
          if (m_q.size() < DEPTH) m_q.push_back({4'(idx), sense});
          else m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input logic [15:0] sel, input logic sense, input logic rdy);
    @(negedge CLK);
    SEL = sel; SENSE = sense; EVT_READY = rdy;
    #1;
    check_outputs();
    model_step(sel, sense, rdy);
  endtask

  task automatic settle();
    @(posedge CLK);
    #1;
  endtask

  // reset with a legal sample and a ready consumer, both must be overridden
  task automatic do_reset();
    @(negedge CLK);
    CLRBAR = 1'b1; SEL = ~16'h0001; SENSE = 1'b1; EVT_READY = 1'b1;
    @(negedge CLK);
    CLRBAR = 1'b0; SEL = 16'hFFFF; SENSE = 1'b0; EVT_READY = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && m_q.size() > 0; i++) cyc(16'hFFFF, 1'b0, 1'b1);
    settle();
    chk("drained", {15'd0, EVT_VALID}, 16'h0000);
  endtask

  logic [6:0]  seq3;
  logic [15:0] rsel;
  logic [3:0]  tgt;

  initial begin
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_keys", KEYS, 16'h0000);
    chk("rst_valid", {15'd0, EVT_VALID}, 16'h0000);
    chk("rst_code", {12'd0, EVT_CODE}, 16'h0000);
    chk("rst_press", {15'd0, EVT_PRESS}, 16'h0000);
    chk("rst_ovf", {15'd0, OVERFLOW}, 16'h0000);
    @(negedge CLK);
    CLRBAR = 1'b0;

    // key 5 press interleaved with key 0 open samples
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc(~16'h0001, 1'b0, 1'b0);
      cyc(~16'h0020, 1'b1, 1'b0);
    end
    settle();
    chk("k5_keys", KEYS, 16'h0020);
    chk("k5_valid", {15'd0, EVT_VALID}, 16'h0001);
    chk("k5_code", {12'd0, EVT_CODE}, 16'h0005);
    chk("k5_press", {15'd0, EVT_PRESS}, 16'h0001);
    drain();

    // key 3 bounce: 1,1,0,1,1,1,1
    seq3 = 7'b1111011;
    for (int i = 0; i < 7; i++) begin
      cyc(~16'h0008, seq3[i], 1'b0);
      if (i == 5) begin
        settle();
        chk("k3_early", {15'd0, KEYS[3]}, 16'h0000);
        chk("k3_novalid", {15'd0, EVT_VALID}, 16'h0000);
      end
    end
    settle();
    chk("k3_code", {12'd0, EVT_CODE}, 16'h0003);
    chk("k3_press", {15'd0, EVT_PRESS}, 16'h0001);
    drain();

    // key 8: blank and illegal selects must not disturb its counter
    cyc(~16'h0100, 1'b1, 1'b1);
    cyc(~16'h0100, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cyc((i % 2 == 0) ? 16'hFFFF : ~16'h0003, 1'b1, 1'b1);
    cyc(~16'h0100, 1'b1, 1'b1);
    settle();
    chk("k8_hold", {15'd0, KEYS[8]}, 16'h0000);
    cyc(~16'h0100, 1'b1, 1'b1);
    settle();
    chk("k8_flip", {15'd0, KEYS[8]}, 16'h0001);
    for (int i = 0; i < 4; i++) cyc(~16'h0100, 1'b0, 1'b1);
    settle();
    chk("k8_release", {15'd0, KEYS[8]}, 16'h0000);
    drain();

    // overflow: five presses with the consumer stalled
    do_reset();
    for (int k = 1; k <= 5; k++)
      for (int j = 0; j < 4; j++) cyc(~(16'h0001 << k), 1'b1, 1'b0);
    settle();
    chk("ovf_keys", KEYS, 16'h003E);
    chk("ovf_flag", {15'd0, OVERFLOW}, 16'h0001);
    chk("ovf_head", {12'd0, EVT_CODE}, 16'h0001);
    drain();

    // full FIFO popped in the cycle key 7 completes: no overflow
    do_reset();
    for (int k = 1; k <= 4; k++)
      for (int j = 0; j < 4; j++) cyc(~(16'h0001 << k), 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) cyc(~16'h0080, 1'b1, 1'b0);
    cyc(~16'h0080, 1'b1, 1'b1);
    settle();
    chk("full_pop_ovf", {15'd0, OVERFLOW}, 16'h0000);
    chk("full_pop_head", {12'd0, EVT_CODE}, 16'h0002);
    drain();

    // reset mid-debounce with a pending event
    for (int j = 0; j < 4; j++) cyc(~16'h0400, 1'b1, 1'b0);
    cyc(~16'h0200, 1'b1, 1'b0);
    cyc(~16'h0200, 1'b1, 1'b0);
    do_reset();
    settle();
    chk("mid_rst_keys", KEYS, 16'h0000);
    chk("mid_rst_valid", {15'd0, EVT_VALID}, 16'h0000);
    for (int j = 0; j < 3; j++) cyc(~16'h0200, 1'b1, 1'b0);
    settle();
    chk("k9_fresh", KEYS, 16'h0000);
    cyc(~16'h0200, 1'b1, 1'b0);
    settle();
    chk("k9_flip", KEYS, 16'h0200);
    drain();

    // random traffic against the model
    tgt = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      int r, a, b, k;
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 3);
      if ($urandom_range(0, 30) == 0) tgt[k] = ~tgt[k];
      if (r == 0) begin
        rsel = 16'hFFFF;
      end else if (r == 1) begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        rsel = ~((16'h0001 << a) | (16'h0001 << b));
      end else begin
        rsel = ~(16'h0001 << k);
      end
      cyc(rsel, ($urandom_range(0, 7) != 0) ? tgt[k] : ~tgt[k], 1'($urandom_range(0, 2) != 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
